// File: rtl/spi_regfile_peripheral.sv
// SPI (mode 0) slave giving a small register file: write frames load a register,
// read frames return one on CIPO. All SPI pins are resynchronised into clk.
module spi_regfile_peripheral #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int NUM_REGS = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         nCS,
  input  logic                         SCLK,
  input  logic                         COPI,
  output logic                         CIPO,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int HDR_LEN   = 1 + ADDR_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, WAIT_CS} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             cs_q, sclk_q;
  logic [1:0]             copi_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [FRAME_LEN-1:0]   shreg_q, shreg_nxt;
  logic [DATA_W-1:0]      tx_q;
  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic                   wr_strobe_q, frame_err_q;
  logic [ADDR_W-1:0]      wr_addr_q;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_high;
  logic last_bit, frame_start, shift_en, abort, commit, tx_adv, rd_load;
  logic                   c_rw, addr_hit;
  logic [ADDR_W-1:0]      c_addr, h_addr;
  logic [DATA_W-1:0]      c_data, rd_data;

  // Stage [1] is the synchronised value, stage [2] its one-cycle-old copy for edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q   <= 3'b111;
      sclk_q <= 3'b000;
      copi_q <= 2'b00;
    end else begin
      cs_q   <= {cs_q[1:0], nCS};
      sclk_q <= {sclk_q[1:0], SCLK};
      copi_q <= {copi_q[0], COPI};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_high   = cs_q[1];

  assign shreg_nxt = {shreg_q[FRAME_LEN-2:0], copi_q[1]};
  assign h_addr    = shreg_nxt[ADDR_W-1:0];
  assign c_rw      = shreg_q[FRAME_LEN-1];
  assign c_addr    = shreg_q[DATA_W +: ADDR_W];
  assign c_data    = shreg_q[DATA_W-1:0];
  assign last_bit  = sclk_rise && (cnt_q == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT: begin
        if (last_bit)     state_d = COMMIT;
        else if (cs_rise) state_d = IDLE;
      end
      COMMIT:  state_d = WAIT_CS;
      // Level test: a chip-select release coinciding with the last SCLK edge must still end the frame.
      WAIT_CS: if (cs_high) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_start = 1'b0;
    shift_en    = 1'b0;
    abort       = 1'b0;
    commit      = 1'b0;
    tx_adv      = 1'b0;
    case (state_q)
      IDLE:   frame_start = cs_fall;
      SHIFT: begin
        shift_en = sclk_rise;
        abort    = cs_rise && !last_bit;
        // The MSB is already on CIPO by the fall after the last address bit, so that fall holds.
        tx_adv   = sclk_fall && (cnt_q > CNT_W'(HDR_LEN));
      end
      COMMIT: commit = 1'b1;
      default: ;
    endcase
  end

  assign rd_load = shift_en && (cnt_q == CNT_W'(HDR_LEN - 1)) && !shreg_nxt[ADDR_W];

  always_comb begin
    rd_data  = '0;
    addr_hit = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (h_addr == ADDR_W'(k)) rd_data = regs_q[k];
      if (c_addr == ADDR_W'(k)) addr_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      shreg_q     <= '0;
      tx_q        <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      frame_err_q <= abort;
      if (frame_start) begin
        cnt_q   <= '0;
        shreg_q <= '0;
        tx_q    <= '0;
      end
      if (shift_en) begin
        shreg_q <= shreg_nxt;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (rd_load)     tx_q <= rd_data;
      else if (tx_adv) tx_q <= {tx_q[DATA_W-2:0], 1'b0};
      if (cs_high)     tx_q <= '0;
      if (commit && c_rw && addr_hit) begin
        wr_strobe_q <= 1'b1;
        wr_addr_q   <= c_addr;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (c_addr == ADDR_W'(k)) regs_q[k] <= c_data;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign CIPO      = tx_q[DATA_W-1];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule
